pre_interleaver_v2: RTL

Parametrised ping-pong block interleaver/de-interleaver for the encoder datapath. It sits between the codeword framer and the channel mapper, and replaces the fixed 32-bit interleave-only version. It adds selectable data width, a per-block interleave/de-interleave mode, AXIS tlast framing with error flagging, and a registered output driven from synchronous-read RAM. Sustained throughput is one beat per cycle.

---
 rtl/pre_interleaver_pkg.sv | 19 +
 rtl/interleaver_addr_gen.sv | 70 +++++++
 rtl/pre_interleaver_v2.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pre_interleaver_pkg.sv
`default_nettype none
// ============================================================================
// pre_interleaver_pkg : shared mode encoding and counter width helper
// Rev 2.0
// ============================================================================
package pre_interleaver_pkg;

  typedef enum logic {
    MODE_INTLV   = 1'b0,
    MODE_DEINTLV = 1'b1
  } mode_e;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/interleaver_addr_gen.sv
`default_nettype none
// ============================================================================
// interleaver_addr_gen : two nested wrapping counters (cw, idx) with a
// selectable inner counter, advance enable and end-of-block flag.
// Rev 2.0
// ============================================================================
module interleaver_addr_gen
  import pre_interleaver_pkg::*;
#(
  parameter int NUM_CW = 4,
  parameter int CW_LEN = 65,
  parameter int CW_W   = cnt_w(NUM_CW),
  parameter int IDX_W  = cnt_w(CW_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idx_inner,
  input  logic             adv,
  output logic [CW_W-1:0]  cw,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [CW_W-1:0]  CW_MAX  = CW_W'(NUM_CW - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CW_LEN - 1);

  logic [CW_W-1:0]  cw_q, cw_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign cw   = cw_q;
  assign idx  = idx_q;
  assign last = (cw_q == CW_MAX) && (idx_q == IDX_MAX);

  always_comb begin
    cw_d  = cw_q;
    idx_d = idx_q;
    if (adv) begin
      if (last) begin
        cw_d  = '0;
        idx_d = '0;
      end else if (idx_inner) begin
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
          cw_d  = cw_q + 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        if (cw_q == CW_MAX) begin
          cw_d  = '0;
          idx_d = idx_q + 1'b1;
        end else begin
          cw_d = cw_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cw_q  <= '0;
      idx_q <= '0;
    end else begin
      cw_q  <= cw_d;
      idx_q <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pre_interleaver_v2.sv
`default_nettype none
// ============================================================================
// pre_interleaver_v2 : ping-pong block interleaver / de-interleaver with
// per-block mode, tlast checking and a registered AXIS output.
// Rev 2.0
// ============================================================================
module pre_interleaver_v2
  import pre_interleaver_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CW_LEN     = 65,
  parameter int NUM_CW     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_mode,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  err_tlast
);

  localparam int BLK    = CW_LEN * NUM_CW;
  localparam int CW_W   = cnt_w(NUM_CW);
  localparam int IDX_W  = cnt_w(CW_LEN);
  localparam int ADDR_W = cnt_w(2 * BLK);

  logic [1:0]            full_q, full_d;
  logic [1:0]            bank_mode_q, bank_mode_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_lst_q, rd_lst_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] ram_rd_q;
  logic [DATA_WIDTH-1:0] mem [2*BLK];

  logic [CW_W-1:0]   wr_cw, rd_cw;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_last, rd_last, wr_first;
  logic              accept, pipe_en, rd_en;
  mode_e             wr_mode, rd_mode;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  assign s_axis_tready = !full_q[wr_bank_q];
  assign accept        = s_axis_tvalid && s_axis_tready;
  // The RAM read register and the output register advance together, so a
  // beat parked in the RAM register during a stall is never overwritten.
  assign pipe_en       = !m_valid_q || m_axis_tready;
  assign rd_en         = full_q[rd_bank_q] && pipe_en;

  // A new block's first address is (0,0) in either mode, so the live
  // cfg_mode only steers the step taken out of that first beat.
  assign wr_first = (wr_cw == '0) && (wr_idx == '0);
  assign wr_mode  = wr_first ? mode_e'(cfg_mode) : mode_e'(bank_mode_q[wr_bank_q]);
  assign rd_mode  = mode_e'(bank_mode_q[rd_bank_q]);

  assign wr_addr = (wr_bank_q ? ADDR_W'(BLK) : ADDR_W'(0))
                 + ADDR_W'(wr_cw) * ADDR_W'(CW_LEN) + ADDR_W'(wr_idx);
  assign rd_addr = (rd_bank_q ? ADDR_W'(BLK) : ADDR_W'(0))
                 + ADDR_W'(rd_cw) * ADDR_W'(CW_LEN) + ADDR_W'(rd_idx);

  interleaver_addr_gen #(
    .NUM_CW (NUM_CW),
    .CW_LEN (CW_LEN),
    .CW_W   (CW_W),
    .IDX_W  (IDX_W)
  ) u_wr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx_inner (wr_mode == MODE_INTLV),
    .adv       (accept),
    .cw        (wr_cw),
    .idx       (wr_idx),
    .last      (wr_last)
  );

  interleaver_addr_gen #(
    .NUM_CW (NUM_CW),
    .CW_LEN (CW_LEN),
    .CW_W   (CW_W),
    .IDX_W  (IDX_W)
  ) u_rd_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx_inner (rd_mode == MODE_DEINTLV),
    .adv       (rd_en),
    .cw        (rd_cw),
    .idx       (rd_idx),
    .last      (rd_last)
  );

  always_comb begin
    full_d      = full_q;
    bank_mode_d = bank_mode_q;
    if (rd_en && rd_last) full_d[rd_bank_q] = 1'b0;
    if (accept && wr_last) full_d[wr_bank_q] = 1'b1;
    if (accept && wr_first) bank_mode_d[wr_bank_q] = cfg_mode;
    wr_bank_d = wr_bank_q ^ (accept && wr_last);
    rd_bank_d = rd_bank_q ^ (rd_en && rd_last);

    rd_vld_d  = rd_vld_q;
    rd_lst_d  = rd_lst_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    if (pipe_en) begin
      rd_vld_d  = rd_en;
      rd_lst_d  = rd_en && rd_last;
      m_valid_d = rd_vld_q;
      m_last_d  = rd_lst_q;
      if (rd_vld_q) m_data_d = ram_rd_q;
    end

    err_d = accept && (s_axis_tlast != wr_last);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q      <= '0;
      bank_mode_q <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_lst_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      full_q      <= full_d;
      bank_mode_q <= bank_mode_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      rd_vld_q    <= rd_vld_d;
      rd_lst_q    <= rd_lst_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= s_axis_tdata;
    if (rd_en) ram_rd_q <= mem[rd_addr];
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign err_tlast     = err_q;

endmodule
`default_nettype wire
